// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential shift-add signed multiplier among NREQ requesters.
// Optional RUN/FLUSH watchdog with sticky err output is compiled in with `define MULARB_TIMEOUT_EN.
module mul_arbiter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 2,
  parameter int unsigned TMO  = 63
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   a_in,
  input  logic [NREQ*DW-1:0]   b_in,
  output logic [NREQ-1:0]      ack,
  output logic [2*DW-1:0]      res,
  output logic                 busy,
`ifdef MULARB_TIMEOUT_EN
  output logic                 err,
`endif
  output logic                 m_mul,
  input  logic                 m_stall,
  output logic [DW-1:0]        m_a,
  output logic [DW-1:0]        m_b,
  input  logic [2*DW-1:0]      m_res
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_g;
  logic [GW-1:0]      r_rr;
  logic [GW-1:0]      w_g;
  logic [GW-1:0]      w_idx;
  logic [GW-1:0]      w_rr_nxt;
  logic               w_any;
  logic               w_tmo;
  logic [NREQ-1:0]    r_ack;
  logic [2*DW-1:0]    r_res;
  logic [DW-1:0]      r_a;
  logic [DW-1:0]      r_b;

`ifdef MULARB_TIMEOUT_EN
  localparam int unsigned TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  logic [TW-1:0] r_tmo;
  logic          r_err;

  assign w_tmo = ((r_state == S_FLUSH) || (r_state == S_RUN)) && m_stall
                 && (r_tmo == TW'(TMO));
  assign err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_tmo <= '0;
      end else if (r_tmo != TW'(TMO)) begin
        r_tmo <= r_tmo + TW'(1);
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_tmo = 1'b0;

  // TMO only sizes the watchdog; without it the parameter is inert.
  if (TMO == 0) begin : g_tmo_inert
  end
`endif

  // Round-robin pick: first request at or after r_rr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = GW'((32'(r_rr) + k) % NREQ);
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_g   = w_idx;
      end
    end
  end

  assign w_rr_nxt = (w_g == GW'(NREQ - 1)) ? '0 : w_g + GW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FLUSH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FLUSH: if (!m_stall || w_tmo) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_any) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_tmo) begin
          w_state_nxt = S_FLUSH;
        end else if (!m_stall) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_FLUSH;
    endcase
  end

  // m_mul must drop in the same cycle stall goes low, otherwise the
  // multiplier re-arms and loses its completed count; gated by reset too.
  always_comb begin
    m_mul = 1'b0;
    unique case (r_state)
      S_FLUSH: m_mul = m_stall && !w_tmo;
      S_ARM:   m_mul = 1'b1;
      S_RUN:   m_mul = m_stall && !w_tmo;
      default: m_mul = 1'b0;
    endcase
    if (!rst_n) begin
      m_mul = 1'b0;
    end
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= '0;
      r_res <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_rr  <= '0;
      r_g   <= '0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a  <= a_in[32'(w_g)*DW +: DW];
            r_b  <= b_in[32'(w_g)*DW +: DW];
            r_g  <= w_g;
            r_rr <= w_rr_nxt;
          end
        end
        S_RUN: begin
          if (w_tmo) begin
            r_ack[r_g] <= 1'b1;
            r_res      <= '0;
            r_a        <= '0;
            r_b        <= '0;
          end else if (!m_stall) begin
            r_ack[r_g] <= 1'b1;
            r_res      <= m_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ack = r_ack;
  assign res = r_res;
  assign m_a = r_a;
  assign m_b = r_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed scoreboard bench for mul_arbiter with a behavioural shift-add multiplier model
// whose step counter is never reset.
module tb_mul_arbiter;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREQ = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   a_in = '0;
  logic [NREQ*DW-1:0]   b_in = '0;
  logic [NREQ-1:0]      ack;
  logic [2*DW-1:0]      res;
  logic                 busy;
  logic                 m_mul;
  logic                 m_stall;
  logic [DW-1:0]        m_a;
  logic [DW-1:0]        m_b;
  logic [2*DW-1:0]      m_res;
`ifdef MULARB_TIMEOUT_EN
  logic                 err;
`endif

  int   cnt = 0;
  logic stall_force = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  typedef struct {
    int          idx;
    logic [63:0] res;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    x = $signed(a);
    y = $signed(b);
    return 64'(x * y);
  endfunction

  always #5 clk = ~clk;

  // Multiplier model: steps while mul&stall, re-arms on mul&!stall, done at DW.
  always @(posedge clk) begin
    if (m_mul) cnt <= m_stall ? cnt + 1 : 0;
  end
  assign m_stall = stall_force || (cnt != 32);
  assign m_res   = (cnt == 32) ? prod(m_a, m_b) : 64'hDEADBEEF_DEADBEEF;

  mul_arbiter #(.DW(DW), .NREQ(NREQ), .TMO(63)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .ack    (ack),
    .res    (res),
    .busy   (busy),
`ifdef MULARB_TIMEOUT_EN
    .err    (err),
`endif
    .m_mul  (m_mul),
    .m_stall(m_stall),
    .m_a    (m_a),
    .m_b    (m_b),
    .m_res  (m_res)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    a_in[i*DW +: DW] = a;
    b_in[i*DW +: DW] = b;
    req[i] = 1'b1;
    e.idx = i;
    e.res = prod(a, b);
    sbq.push_back(e);
  endtask

  task automatic wait_ack(input int exp_lat, input bit rereq);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (ack != '0) begin
        lat = n;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      ncmp++;
      nerr++;
      $error("FAIL ack_wait: observed no ack expected ack within 200 cycles");
      return;
    end
    if (sbq.size() == 0) begin
      ncmp++;
      nerr++;
      $error("FAIL scoreboard: observed ack %b expected no ack", ack);
      return;
    end
    e = sbq.pop_front();
    check("ack_onehot", 64'(ack), 64'(1) << e.idx);
    check("product", res, e.res);
    if (exp_lat > 0) check("ack_latency", 64'(lat), 64'(exp_lat));
    req[e.idx] = 1'b0;
    step();
    check("ack_pulse_width", 64'(ack), 64'(0));
    if (rereq) begin
      req[e.idx] = 1'b1;
      sbq.push_back(e);
    end
  endtask

  task automatic count_flush(input int exp_cycles);
    int n;
    step();
    check("flush_mul_on", 64'(m_mul), 64'(1));
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("flush_cycles", 64'(n), 64'(exp_cycles));
    check("idle_mul_off", 64'(m_mul), 64'(0));
  endtask

  initial begin
    // Reset values with multiplier counter at 0.
    step();
    step();
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_res", res, 64'(0));
    check("rst_mul", 64'(m_mul), 64'(0));
    check("rst_ma", 64'(m_a), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    rst_n = 1'b1;
    count_flush(33);
    check("idle_res", res, 64'(0));

    // Single request, latency and ack width.
    issue(0, 32'd7, 32'hFFFF_FFFD);
    wait_ack(35, 1'b0);

    // Both requesting continuously; rr pointer is 1 after the previous grant.
    a_in[DW +: DW] = 32'd123456789;
    b_in[DW +: DW] = 32'hFFFF_FC18;
    a_in[0 +: DW]  = 32'h8000_0000;
    b_in[0 +: DW]  = 32'h8000_0000;
    issue(1, 32'd123456789, 32'hFFFF_FC18);
    issue(0, 32'h8000_0000, 32'h8000_0000);
    wait_ack(35, 1'b1);
    wait_ack(35, 1'b1);
    wait_ack(35, 1'b0);
    wait_ack(35, 1'b0);

    // Operands changed and req dropped mid-RUN do not affect the product.
    issue(0, 32'd5, 32'd6);
    for (int i = 0; i < 10; i++) step();
    a_in[0 +: DW] = 32'd99;
    req[0] = 1'b0;
    wait_ack(25, 1'b0);

    // Asynchronous reset mid-RUN (multiplier counter at 8), then drain.
    a_in[0 +: DW] = 32'd3;
    b_in[0 +: DW] = 32'd4;
    req[0] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    req = '0;
    #1;
    check("async_rst_ack", 64'(ack), 64'(0));
    check("async_rst_res", res, 64'(0));
    check("async_rst_mul", 64'(m_mul), 64'(0));
    check("async_rst_ma", 64'(m_a), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(1));
    step();
    rst_n = 1'b1;
    count_flush(25);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ack(35, 1'b0);

`ifdef MULARB_TIMEOUT_EN
    // Watchdog: stall stuck high.
    begin
      exp_t e;
      stall_force = 1'b1;
      a_in[0 +: DW] = 32'd2;
      b_in[0 +: DW] = 32'd3;
      req[0] = 1'b1;
      e.idx = 0;
      e.res = '0;
      sbq.push_back(e);
      wait_ack(0, 1'b0);
      check("tmo_err", 64'(err), 64'(1));
      check("tmo_busy_flush", 64'(busy), 64'(1));
      for (int n = 0; n < 200 && busy === 1'b1; n++) step();
      check("tmo_flush_exit", 64'(busy), 64'(0));
      check("tmo_err_sticky", 64'(err), 64'(1));
    end
`endif

    check("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
